// File: rtl/irq_conditioner_pkg.sv
// Shared constants and mode encodings for the external interrupt conditioning path.
// No timing of its own; imported by the conditioner top and its per-line filter.
package irq_conditioner_pkg;

    localparam int EXT_IRQ_COUNT_DEF = 4;
    localparam int FILT_CNT_W        = 4;

    typedef enum logic {
        IRQ_MODE_LEVEL = 1'b0,
        IRQ_MODE_EDGE  = 1'b1
    } irq_mode_e;

endpackage

// File: rtl/irq_line_filter.sv
// Single-line synchroniser plus glitch filter: out follows in once FILTER_LEN synced samples agree.
// Latency SYNC_STAGES + FILTER_LEN edges; no backpressure, the line is sampled every cycle.
module irq_line_filter
    import irq_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic rstN,
    input  logic in,
    output logic out
);

    localparam logic [FILT_CNT_W-1:0] CNT_MAX = FILT_CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FILT_CNT_W-1:0]  cnt_q, cnt_d;
    logic                   f_q, f_d;
    logic                   s;

    assign s   = sync_q[SYNC_STAGES-1];
    assign out = f_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in};
        cnt_d  = cnt_q;
        f_d    = f_q;
        if (s == f_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            // Enough consecutive disagreeing samples: accept the new level.
            f_d   = s;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync_q <= '0;
            cnt_q  <= '0;
            f_q    <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            f_q    <= f_d;
        end
    end

endmodule

// File: rtl/irq_conditioner.sv
// Conditions raw interrupt lines: sync, glitch filter, edge/level qualify, pending latch, mask.
// Latency SYNC_STAGES+FILTER_LEN+2 edges to irqBus; no backpressure, edge events wait for irqAck.
module irq_conditioner
    import irq_conditioner_pkg::*;
#(
    parameter int EXT_IRQ_COUNT = EXT_IRQ_COUNT_DEF,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_LEN    = 3
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic [EXT_IRQ_COUNT-1:0] irqIn,
    input  logic [EXT_IRQ_COUNT-1:0] edgeMode,
    input  logic [EXT_IRQ_COUNT-1:0] irqEnable,
    input  logic [EXT_IRQ_COUNT-1:0] irqAck,
    output logic [EXT_IRQ_COUNT-1:0] pending,
    output logic [EXT_IRQ_COUNT-1:0] irqBus
);

    logic [EXT_IRQ_COUNT-1:0] filt;
    logic [EXT_IRQ_COUNT-1:0] rise;
    logic [EXT_IRQ_COUNT-1:0] prev_q, prev_d;
    logic [EXT_IRQ_COUNT-1:0] pending_q, pending_d;
    logic [EXT_IRQ_COUNT-1:0] irq_bus_q, irq_bus_d;

    for (genvar g = 0; g < EXT_IRQ_COUNT; g++) begin : g_line
        irq_line_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
        ) u_filter (
            .clk  (clk),
            .rstN (rstN),
            .in   (irqIn[g]),
            .out  (filt[g])
        );
    end

    assign rise = filt & ~prev_q;

    always_comb begin
        prev_d    = filt;
        irq_bus_d = pending_q & irqEnable;
        pending_d = pending_q;
        for (int i = 0; i < EXT_IRQ_COUNT; i++) begin
            if (irq_mode_e'(edgeMode[i]) == IRQ_MODE_EDGE) begin
                // Set beats clear so a rise coinciding with an ack is never lost.
                if (rise[i]) begin
                    pending_d[i] = 1'b1;
                end else if (irqAck[i]) begin
                    pending_d[i] = 1'b0;
                end
            end else begin
                pending_d[i] = filt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            prev_q    <= '0;
            pending_q <= '0;
            irq_bus_q <= '0;
        end else begin
            prev_q    <= prev_d;
            pending_q <= pending_d;
            irq_bus_q <= irq_bus_d;
        end
    end

    assign pending = pending_q;
    assign irqBus  = irq_bus_q;

endmodule

// File: tb/tb_irq_conditioner.sv
// Scoreboard bench for irq_conditioner with default parameters (4 lines, 2 sync stages, filter 3).
// Inputs change just after a falling edge; outputs are compared at the following falling edge.
module tb_irq_conditioner;

    logic       clk;
    logic       rstN;
    logic [3:0] irqIn;
    logic [3:0] edgeMode;
    logic [3:0] irqEnable;
    logic [3:0] irqAck;
    logic [3:0] pending;
    logic [3:0] irqBus;

    int errors = 0;
    int checks = 0;

    // rel = rising edge number counted from the first edge that samples the task's stimulus
    typedef struct {
        int       rel;
        logic [3:0] pm;
        logic [3:0] pend;
        logic [3:0] bm;
        logic [3:0] bus;
    } exp_t;

    exp_t sb[$];

    irq_conditioner dut (
        .clk       (clk),
        .rstN      (rstN),
        .irqIn     (irqIn),
        .edgeMode  (edgeMode),
        .irqEnable (irqEnable),
        .irqAck    (irqAck),
        .pending   (pending),
        .irqBus    (irqBus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void push(input int rel, input logic [3:0] pm, input logic [3:0] pend,
                                 input logic [3:0] bm, input logic [3:0] bus);
        exp_t e;
        e.rel  = rel;
        e.pm   = pm;
        e.pend = pend;
        e.bm   = bm;
        e.bus  = bus;
        sb.push_back(e);
    endfunction

    task automatic quiesce();
        irqIn     = 4'h0;
        irqAck    = 4'h0;
        edgeMode  = 4'h0;
        irqEnable = 4'hF;
        rstN      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        rstN      = 1'b0;
        irqIn     = 4'hF;
        irqAck    = 4'h0;
        edgeMode  = 4'h0;
        irqEnable = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (pending !== 4'h0 || irqBus !== 4'h0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d pending=%h irqBus=%h required 0/0", k, pending, irqBus);
            end
        end
        rstN = 1'b1;
        push(1, 4'hF, 4'h0, 4'hF, 4'h0);
        push(3, 4'hF, 4'h0, 4'hF, 4'h0);
        push(5, 4'hF, 4'h0, 4'hF, 4'h0);
        push(6, 4'hF, 4'hF, 4'hF, 4'h0);
        push(7, 4'hF, 4'hF, 4'hF, 4'hF);
        push(8, 4'hF, 4'hF, 4'hF, 4'hF);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            while (sb.size() != 0 && sb[0].rel <= k + 1) begin
                e = sb.pop_front();
                checks++;
                if ((pending & e.pm) !== (e.pend & e.pm) || (irqBus & e.bm) !== (e.bus & e.bm)) begin
                    errors++;
                    $display("FAIL reset_release rel=%0d pending=%h irqBus=%h required pending=%h/%h irqBus=%h/%h",
                             e.rel, pending, irqBus, e.pend, e.pm, e.bus, e.bm);
                end
            end
        end
        if (sb.size() != 0) begin
            errors++; checks++;
            $display("FAIL reset_release leftover=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_edge_capture();
        exp_t e;
        quiesce();
        edgeMode = 4'h1;
        push(5,  4'h1, 4'h0, 4'h1, 4'h0);
        push(6,  4'h1, 4'h1, 4'h1, 4'h0);
        push(7,  4'h1, 4'h1, 4'h1, 4'h1);
        push(15, 4'h1, 4'h1, 4'h1, 4'h1);
        push(21, 4'h1, 4'h0, 4'h1, 4'h1);
        push(22, 4'h1, 4'h0, 4'h1, 4'h0);
        push(24, 4'h1, 4'h0, 4'h1, 4'h0);
        for (int k = 0; k < 24; k++) begin
            irqIn[0]  = (k < 10);
            irqAck[0] = (k == 20);
            @(negedge clk);
            while (sb.size() != 0 && sb[0].rel <= k + 1) begin
                e = sb.pop_front();
                checks++;
                if ((pending & e.pm) !== (e.pend & e.pm) || (irqBus & e.bm) !== (e.bus & e.bm)) begin
                    errors++;
                    $display("FAIL edge_capture rel=%0d pending=%h irqBus=%h required pending=%h/%h irqBus=%h/%h",
                             e.rel, pending, irqBus, e.pend, e.pm, e.bus, e.bm);
                end
            end
        end
        if (sb.size() != 0) begin
            errors++; checks++;
            $display("FAIL edge_capture leftover=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        quiesce();
        for (int r = 4; r <= 16; r += 2) push(r, 4'h2, 4'h0, 4'h0, 4'h0);
        push(17, 4'h2, 4'h0, 4'h0, 4'h0);
        push(18, 4'h2, 4'h2, 4'h0, 4'h0);
        push(19, 4'h2, 4'h2, 4'h0, 4'h0);
        push(20, 4'h2, 4'h2, 4'h0, 4'h0);
        push(21, 4'h2, 4'h0, 4'h0, 4'h0);
        for (int k = 0; k < 24; k++) begin
            irqIn[1] = (k < 2) || (k >= 12 && k < 15);
            @(negedge clk);
            while (sb.size() != 0 && sb[0].rel <= k + 1) begin
                e = sb.pop_front();
                checks++;
                if ((pending & e.pm) !== (e.pend & e.pm) || (irqBus & e.bm) !== (e.bus & e.bm)) begin
                    errors++;
                    $display("FAIL glitch rel=%0d pending=%h irqBus=%h required pending=%h/%h irqBus=%h/%h",
                             e.rel, pending, irqBus, e.pend, e.pm, e.bus, e.bm);
                end
            end
        end
        if (sb.size() != 0) begin
            errors++; checks++;
            $display("FAIL glitch leftover=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_ack_collision();
        exp_t e;
        quiesce();
        edgeMode = 4'h4;
        push(6,  4'h4, 4'h4, 4'h0, 4'h0);
        push(9,  4'h4, 4'h4, 4'h0, 4'h0);
        push(10, 4'h4, 4'h0, 4'h0, 4'h0);
        push(16, 4'h4, 4'h0, 4'h0, 4'h0);
        push(17, 4'h4, 4'h4, 4'h4, 4'h0);
        push(18, 4'h4, 4'h4, 4'h4, 4'h4);
        push(20, 4'h4, 4'h4, 4'h0, 4'h0);
        push(23, 4'h4, 4'h0, 4'h0, 4'h0);
        push(24, 4'h4, 4'h0, 4'h4, 4'h0);
        for (int k = 0; k < 24; k++) begin
            irqIn[2]  = (k < 4) || (k >= 11);
            irqAck[2] = (k == 9) || (k == 16) || (k == 22);
            @(negedge clk);
            while (sb.size() != 0 && sb[0].rel <= k + 1) begin
                e = sb.pop_front();
                checks++;
                if ((pending & e.pm) !== (e.pend & e.pm) || (irqBus & e.bm) !== (e.bus & e.bm)) begin
                    errors++;
                    $display("FAIL ack_collision rel=%0d pending=%h irqBus=%h required pending=%h/%h irqBus=%h/%h",
                             e.rel, pending, irqBus, e.pend, e.pm, e.bus, e.bm);
                end
            end
        end
        if (sb.size() != 0) begin
            errors++; checks++;
            $display("FAIL ack_collision leftover=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_mask_level();
        exp_t e;
        quiesce();
        push(5,  4'h8, 4'h0, 4'h8, 4'h0);
        push(6,  4'h8, 4'h8, 4'h8, 4'h0);
        push(10, 4'h8, 4'h8, 4'h8, 4'h0);
        push(11, 4'h8, 4'h8, 4'h8, 4'h8);
        push(13, 4'h8, 4'h8, 4'h8, 4'h8);
        push(19, 4'h8, 4'h8, 4'h8, 4'h8);
        push(20, 4'h8, 4'h0, 4'h8, 4'h8);
        push(21, 4'h8, 4'h0, 4'h8, 4'h0);
        for (int k = 0; k < 22; k++) begin
            irqIn[3]  = (k < 14);
            irqAck[3] = (k >= 11 && k <= 17);
            irqEnable = (k >= 10) ? 4'hF : 4'h7;
            @(negedge clk);
            while (sb.size() != 0 && sb[0].rel <= k + 1) begin
                e = sb.pop_front();
                checks++;
                if ((pending & e.pm) !== (e.pend & e.pm) || (irqBus & e.bm) !== (e.bus & e.bm)) begin
                    errors++;
                    $display("FAIL mask_level rel=%0d pending=%h irqBus=%h required pending=%h/%h irqBus=%h/%h",
                             e.rel, pending, irqBus, e.pend, e.pm, e.bus, e.bm);
                end
            end
        end
        if (sb.size() != 0) begin
            errors++; checks++;
            $display("FAIL mask_level leftover=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        quiesce();
        edgeMode = 4'h1;
        irqIn    = 4'h9;
        repeat (8) @(negedge clk);
        checks++;
        if (pending !== 4'h9 || irqBus !== 4'h9) begin
            errors++;
            $display("FAIL async_setup pending=%h irqBus=%h required 9/9", pending, irqBus);
        end
        #2;
        rstN  = 1'b0;
        irqIn = 4'h0;
        #1;
        checks++;
        if (pending !== 4'h0 || irqBus !== 4'h0) begin
            errors++;
            $display("FAIL async_immediate pending=%h irqBus=%h required 0/0", pending, irqBus);
        end
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        push(3,  4'hF, 4'h0, 4'hF, 4'h0);
        push(10, 4'hF, 4'h0, 4'hF, 4'h0);
        push(15, 4'hF, 4'h0, 4'hF, 4'h0);
        push(16, 4'hF, 4'h1, 4'hF, 4'h0);
        push(17, 4'hF, 4'h1, 4'hF, 4'h1);
        for (int k = 0; k < 18; k++) begin
            irqIn[0] = (k >= 10);
            @(negedge clk);
            while (sb.size() != 0 && sb[0].rel <= k + 1) begin
                e = sb.pop_front();
                checks++;
                if ((pending & e.pm) !== (e.pend & e.pm) || (irqBus & e.bm) !== (e.bus & e.bm)) begin
                    errors++;
                    $display("FAIL async_recapture rel=%0d pending=%h irqBus=%h required pending=%h/%h irqBus=%h/%h",
                             e.rel, pending, irqBus, e.pend, e.pm, e.bus, e.bm);
                end
            end
        end
        if (sb.size() != 0) begin
            errors++; checks++;
            $display("FAIL async_recapture leftover=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_edge_capture();
        test_glitch();
        test_ack_collision();
        test_mask_level();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
